// File: rtl/mc_pkg.sv
// Shared definitions for the iterative AES MixColumns engine.
// MIX_COLUMNS_INV_EN adds the InvMixColumns multipliers (09/0b/0d/0e) to gmul.
package mc_pkg;

  localparam int unsigned BYTES = 16;
  localparam int unsigned IDX_W = $clog2(BYTES);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mc_state_e;

  localparam logic [7:0] AES_POLY = 8'h1b;

  // Row constants {k0,k1,k2,k3}, applied to column bytes {a0,a1,a2,a3}.
  localparam logic [31:0] FWD_ROW [0:3] = '{32'h02030101, 32'h01020301,
                                           32'h01010203, 32'h03010102};
  localparam logic [31:0] INV_ROW [0:3] = '{32'h0e0b0d09, 32'h090e0b0d,
                                           32'h0d090e0b, 32'h0b0d090e};

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
  endfunction

  // Multiply by one of the small MixColumns constants; unsupported k gives 0.
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] k);
    logic [7:0] x2;
    logic [7:0] res;
`ifdef MIX_COLUMNS_INV_EN
    logic [7:0] x4;
    logic [7:0] x8;
`endif
    x2  = xtime(x);
`ifdef MIX_COLUMNS_INV_EN
    x4  = xtime(x2);
    x8  = xtime(x4);
`endif
    res = 8'h00;
    case (k)
      8'h01: res = x;
      8'h02: res = x2;
      8'h03: res = x2 ^ x;
`ifdef MIX_COLUMNS_INV_EN
      8'h09: res = x8 ^ x;
      8'h0b: res = x8 ^ x2 ^ x;
      8'h0d: res = x8 ^ x4 ^ x;
      8'h0e: res = x8 ^ x4 ^ x2;
`endif
      default: res = 8'h00;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mc_byte_dot.sv
// Combinational GF(2^8) dot product of one state column with one row-constant word.
module mc_byte_dot
  import mc_pkg::*;
(
  input  logic [31:0] col,
  input  logic [31:0] k,
  output logic [7:0]  prod_c
);

  // XOR of the four byte products; byte 0 is the most significant.
  always_comb begin
    prod_c = gmul(col[31:24], k[31:24]) ^ gmul(col[23:16], k[23:16]) ^
             gmul(col[15:8],  k[15:8])  ^ gmul(col[7:0],   k[7:0]);
  end

endmodule

// File: rtl/mix_columns_seq.sv
// Iterative AES MixColumns: one output byte per clock through a shared dot-product unit.
// Define MIX_COLUMNS_INV_EN to add the inv port and InvMixColumns constants.
module mix_columns_seq
  import mc_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
`ifdef MIX_COLUMNS_INV_EN
  input  logic         inv,
`endif
  input  logic [127:0] state_in,
  output logic         busy,
  output logic         done,
  output logic [127:0] state_out
);

  mc_state_e          state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [127:0]       cap_q, cap_d;
  logic [127:0]       out_q, out_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [31:0]        col_c;
  logic [31:0]        row_c;
  logic [7:0]         prod_c;
`ifdef MIX_COLUMNS_INV_EN
  logic               inv_q, inv_d;
`endif

  // Operand select: idx[3:2] picks the column, idx[1:0] the row constants.
  always_comb begin
    col_c = cap_q[{~idx_q[3:2], 5'b00000} +: 32];
`ifdef MIX_COLUMNS_INV_EN
    row_c = inv_q ? INV_ROW[idx_q[1:0]] : FWD_ROW[idx_q[1:0]];
`else
    row_c = FWD_ROW[idx_q[1:0]];
`endif
  end

  mc_byte_dot u_dot (
    .col    (col_c),
    .k      (row_c),
    .prod_c (prod_c)
  );

  // Next-state logic: capture on start in IDLE, write one byte per cycle in RUN.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cap_d   = cap_q;
    out_d   = out_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef MIX_COLUMNS_INV_EN
    inv_d   = inv_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          cap_d   = state_in;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
`ifdef MIX_COLUMNS_INV_EN
          inv_d   = inv;
`endif
        end
      end
      RUN: begin
        // Byte (c,r) sits at flat byte position idx from the MSB end.
        out_d[{~idx_q, 3'b000} +: 8] = prod_c;
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(BYTES - 1)) begin
          idx_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cap_q   <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef MIX_COLUMNS_INV_EN
      inv_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cap_q   <= cap_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef MIX_COLUMNS_INV_EN
      inv_q   <= inv_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign state_out = out_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Scoreboard bench for mix_columns_seq: stimulus pushes expected results, a monitor checks each done.
module tb_mix_columns_seq;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] state_in;
  logic         busy;
  logic         done;
  logic [127:0] state_out;
`ifdef MIX_COLUMNS_INV_EN
  logic         inv;
`endif

  int checks;
  int failures;
  int done_seen;
  int busy_cnt;
  logic prev_done;
  logic [127:0] sb_q[$];

  localparam logic [127:0] FIPS_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] FIPS_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;
  localparam logic [127:0] COL_IN   = 128'hdb135345_00000000_00000000_00000000;
  localparam logic [127:0] COL_OUT  = 128'h8e4da1bc_00000000_00000000_00000000;
  localparam logic [127:0] MIX_IN   = 128'hf20a225c_01010101_c6c6c6c6_d4d4d4d5;
  localparam logic [127:0] MIX_OUT  = 128'h9fdc589d_01010101_c6c6c6c6_d5d5d7d6;

  mix_columns_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
`ifdef MIX_COLUMNS_INV_EN
    .inv       (inv),
`endif
    .state_in  (state_in),
    .busy      (busy),
    .done      (done),
    .state_out (state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: count busy cycles, and on every done pop and compare the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      busy_cnt  = 0;
      prev_done = 1'b0;
    end else begin
      if (done) begin
        done_seen++;
        check("done_single_pulse", 128'(prev_done), 128'(0));
        check("busy_low_at_done", 128'(busy), 128'(0));
        check("latency_busy_cycles", 128'(busy_cnt), 128'(16));
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got done with empty scoreboard, expected none");
        end else begin
          check("state_out", state_out, sb_q.pop_front());
        end
        busy_cnt = 0;
      end
      if (busy) busy_cnt++;
      prev_done = done;
    end
  end

  // Issue a start for one cycle and queue its expected result.
  task automatic issue(input logic [127:0] din, input logic [127:0] exp, input logic inv_v);
    sb_q.push_back(exp);
    state_in = din;
    start    = 1'b1;
`ifdef MIX_COLUMNS_INV_EN
    inv      = inv_v;
`else
    if (inv_v) $display("note: inverse request ignored in forward-only build");
`endif
    @(posedge clk);
    #1;
    start    = 1'b0;
`ifdef MIX_COLUMNS_INV_EN
    inv      = 1'b0;
`endif
    state_in = '0;
  endtask

  // Wait for done (sampled on negedge), bounded.
  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (done) break;
      n++;
    end
    if (n >= 40) begin
      checks++;
      failures++;
      $display("FAIL %s: got no done within 40 cycles, expected done", name);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    done_seen = 0;
    busy_cnt  = 0;
    prev_done = 1'b0;
    start     = 1'b0;
    state_in  = '0;
`ifdef MIX_COLUMNS_INV_EN
    inv       = 1'b0;
`endif
    rst       = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 128'(busy), 128'(0));
    check("reset_done", 128'(done), 128'(0));
    check("reset_state_out", state_out, 128'h0);

    // FIPS-197 vector; a conflicting start mid-RUN must be ignored.
    issue(FIPS_IN, FIPS_OUT, 1'b0);
    check("busy_after_start", 128'(busy), 128'(1));
    repeat (4) @(posedge clk);
    #1;
    start    = 1'b1;
    state_in = MIX_IN;
    repeat (2) @(posedge clk);
    #1;
    start    = 1'b0;
    state_in = '0;
    wait_done("fips_done");

    // Back-to-back: start presented during the done cycle.
    issue(COL_IN, COL_OUT, 1'b0);
    wait_done("single_col_done");
    issue(MIX_IN, MIX_OUT, 1'b0);
    wait_done("mixed_done");

    // Abort mid-RUN: outputs clear at once and no done follows.
    @(posedge clk);
    #1;
    issue(MIX_IN, MIX_OUT, 1'b0);
    repeat (6) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_busy", 128'(busy), 128'(0));
    check("abort_done", 128'(done), 128'(0));
    check("abort_state_out", state_out, 128'h0);
    void'(sb_q.pop_back());
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) @(posedge clk);
    check("abort_no_done", 128'(done_seen), 128'(3));

    // Normal operation after the abort.
    #1;
    issue(FIPS_IN, FIPS_OUT, 1'b0);
    wait_done("post_abort_done");
    check("held_state_out", state_out, FIPS_OUT);

`ifdef MIX_COLUMNS_INV_EN
    @(posedge clk);
    #1;
    issue(FIPS_OUT, FIPS_IN, 1'b1);
    wait_done("inv_done");
`endif

    repeat (3) @(posedge clk);
    check("scoreboard_drained", 128'(sb_q.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
